// File: rtl/bcd_scan_pkg.sv
// rtl/bcd_scan_pkg.sv - shared FSM encoding, widths and leading-zero blanking helper
package bcd_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int DIGIT_W     = 4;
  localparam int BIN_W       = 14;
  localparam int BCD_MAX     = 9999;
  localparam int SHIFT_STEPS = BIN_W;

  typedef logic [4*DIGIT_W-1:0] bcd_t;

  // Replace zero digits above the ones digit with 4'hF until the first non-zero digit.
  function automatic bcd_t blank_leading(input bcd_t bcd);
    bcd_t r;
    logic lead;
    r    = bcd;
    lead = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      lead = lead & (bcd[i*DIGIT_W +: DIGIT_W] == 4'd0);
      if (lead) r[i*DIGIT_W +: DIGIT_W] = 4'hF;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_scan_if.sv
// rtl/bcd_scan_if.sv - load/status and digit scan signal bundle for bcd_scan
interface bcd_scan_if;

  logic [bcd_scan_pkg::BIN_W-1:0]   bin_in;
  logic                             load;
  logic                             busy;
  logic                             done;
  logic                             ovf;
  logic [bcd_scan_pkg::DIGIT_W-1:0] digit_bcd;
  logic [3:0]                       digit_sel;

  modport master (
    output bin_in, load,
    input  busy, done, ovf, digit_bcd, digit_sel
  );

  modport slave (
    input  bin_in, load,
    output busy, done, ovf, digit_bcd, digit_sel
  );

endinterface

// File: rtl/bcd_scan_bin2bcd_core.sv
// rtl/bcd_scan_bin2bcd_core.sv - shift-add-3 (double-dabble) datapath, one bit per step
module bin2bcd_core
  import bcd_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic [BIN_W-1:0] bin,
  output bcd_t             bcd
);

  localparam int SR_W = 4*DIGIT_W + BIN_W;

  logic [SR_W-1:0] sr;
  logic [SR_W-1:0] sr_adj;

  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < 4; i++) begin
      if (sr[BIN_W + i*DIGIT_W +: DIGIT_W] >= 4'd5)
        sr_adj[BIN_W + i*DIGIT_W +: DIGIT_W] = sr[BIN_W + i*DIGIT_W +: DIGIT_W] + 4'd3;
    end
  end

  // Input is pre-clamped to 9999, so the MSB shifted out is always zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sr <= '0;
    else if (start)
      sr <= {{(4*DIGIT_W){1'b0}}, bin};
    else if (step)
      sr <= {sr_adj[SR_W-2:0], 1'b0};
  end

  assign bcd = sr[BIN_W +: 4*DIGIT_W];

endmodule

// File: rtl/bcd_scan.sv
// rtl/bcd_scan.sv - binary-to-BCD converter with multiplexed 4-digit scan; BCD_SCAN_BLANK_EN blanks leading zeros
module bcd_scan
  import bcd_scan_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input logic       aclk,
  input logic       aresetn,
  bcd_scan_if.slave bus
);

  localparam int PS_W  = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(SCAN_DIV - 1);

  state_t state;
  state_t state_nxt;
  logic [3:0] step_cnt;
  logic capture;
  logic step;
  logic [BIN_W-1:0] bin_sat;
  logic ovf_q;
  bcd_t core_bcd;
  bcd_t commit_val;

  logic [DIGITS-1:0][DIGIT_W-1:0] display;
  logic [DIGITS-1:0][DIGIT_W-1:0] display_nxt;

  logic [PS_W-1:0] ps;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic wrap;
  logic [DIGIT_W-1:0] digit_bcd_q;
  logic [DIGITS-1:0] digit_sel_q;

  assign bin_sat = (bus.bin_in > BIN_W'(BCD_MAX)) ? BIN_W'(BCD_MAX) : bus.bin_in;

  bin2bcd_core u_core (
    .clk   (aclk),
    .rst_n (aresetn),
    .start (capture),
    .step  (step),
    .bin   (bin_sat),
    .bcd   (core_bcd)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load) begin
          capture   = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (step_cnt == 4'(SHIFT_STEPS - 1)) state_nxt = COMMIT;
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      step_cnt <= '0;
      ovf_q    <= 1'b0;
    end else if (capture) begin
      step_cnt <= '0;
      ovf_q    <= (bus.bin_in > BIN_W'(BCD_MAX));
    end else if (step) begin
      step_cnt <= step_cnt + 4'd1;
    end
  end

`ifdef BCD_SCAN_BLANK_EN
  assign commit_val = blank_leading(core_bcd);
`else
  assign commit_val = core_bcd;
`endif

  // Display only changes in COMMIT, so the scan never shows a partial result.
  assign display_nxt = (state == COMMIT) ? commit_val : display;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) display <= '0;
    else          display <= display_nxt;
  end

  assign wrap    = (ps == PS_LAST);
  assign idx_nxt = wrap ? idx + IDX_W'(1) : idx;

  // Outputs are registered from next-state values so they track display[idx] with no lag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ps          <= '0;
      idx         <= '0;
      digit_sel_q <= ~DIGITS'(1);
      digit_bcd_q <= '0;
    end else begin
      ps          <= wrap ? '0 : ps + PS_W'(1);
      idx         <= idx_nxt;
      digit_sel_q <= ~(DIGITS'(1) << idx_nxt);
      digit_bcd_q <= display_nxt[idx_nxt];
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == COMMIT);
  assign bus.ovf       = ovf_q;
  assign bus.digit_bcd = digit_bcd_q;
  assign bus.digit_sel = digit_sel_q;

endmodule

// File: tb/tb_bcd_scan.sv
// tb/tb_bcd_scan.sv - randomized self-checking bench for bcd_scan against a decimal-arithmetic model
`timescale 1ns/1ps
module tb_bcd_scan;

  localparam int SCAN_DIV = 4;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;

  bcd_scan_if bus ();

  bcd_scan #(.DIGITS(4), .SCAN_DIV(SCAN_DIV)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int cyc;
  logic scan_en = 1'b0;
  logic [3:0] exp_disp [4];

  function automatic logic [3:0] model_digit(input int v, input int i);
    int s;
    int d;
    s = (v > 9999) ? 9999 : v;
    d = (s / (10 ** i)) % 10;
`ifdef BCD_SCAN_BLANK_EN
    if (i > 0 && s < 10 ** i) return 4'hF;
`endif
    return 4'(d);
  endfunction

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Digit index after k clocks out of reset is (k / SCAN_DIV) mod 4.
  always @(negedge aclk) begin
    int idx;
    logic [3:0] exp_sel;
    if (scan_en && aresetn) begin
      idx = (cyc / SCAN_DIV) % 4;
      exp_sel = ~(4'b0001 << idx);
      checks++;
      if (bus.digit_sel !== exp_sel || bus.digit_bcd !== exp_disp[idx]) begin
        errors++;
        $display("FAIL scan cyc=%0d: got sel=%b bcd=%h, want sel=%b bcd=%h",
                 cyc, bus.digit_sel, bus.digit_bcd, exp_sel, exp_disp[idx]);
      end
    end
  end

  task automatic test_reset();
    bus.bin_in = '0;
    bus.load   = 1'b0;
    aresetn    = 1'b0;
    for (int d = 0; d < 4; d++) exp_disp[d] = 4'd0;
    repeat (3) @(negedge aclk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ovf !== 1'b0 ||
        bus.digit_bcd !== 4'd0 || bus.digit_sel !== 4'b1110) begin
      errors++;
      $display("FAIL reset: got busy=%b done=%b ovf=%b bcd=%h sel=%b, want 0 0 0 0 1110",
               bus.busy, bus.done, bus.ovf, bus.digit_bcd, bus.digit_sel);
    end
    aresetn = 1'b1;
  endtask

  task automatic test_scan();
    logic [3:0] seq [5];
    seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    scan_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus.digit_sel !== seq[k] || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL scan_seq step %0d: got sel=%b busy=%b, want sel=%b busy=0",
                 k, bus.digit_sel, bus.busy, seq[k]);
      end
      repeat (SCAN_DIV) @(negedge aclk);
    end
  endtask

  task automatic test_convert(input int v);
    @(negedge aclk);
    bus.bin_in = 14'(v);
    bus.load   = 1'b1;
    @(negedge aclk);
    bus.load = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      if (i > 1) @(negedge aclk);
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== (i == 15)) begin
        errors++;
        $display("FAIL convert %0d cycle %0d: got busy=%b done=%b, want busy=1 done=%b",
                 v, i, bus.busy, bus.done, (i == 15));
      end
    end
    @(posedge aclk);
    #1;
    for (int d = 0; d < 4; d++) exp_disp[d] = model_digit(v, d);
    @(negedge aclk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ovf !== (v > 9999)) begin
      errors++;
      $display("FAIL convert %0d end: got busy=%b done=%b ovf=%b, want busy=0 done=0 ovf=%b",
               v, bus.busy, bus.done, bus.ovf, (v > 9999));
    end
    repeat (4 * SCAN_DIV + 2) @(negedge aclk);
  endtask

  task automatic test_back_to_back();
    @(negedge aclk);
    bus.bin_in = 14'd42;
    bus.load   = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge aclk);
      bus.load = 1'b0;
      if (i == 3) begin
        bus.bin_in = 14'd777;
        bus.load   = 1'b1;
      end
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== (i == 15)) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got busy=%b done=%b, want busy=1 done=%b",
                 i, bus.busy, bus.done, (i == 15));
      end
    end
    @(posedge aclk);
    #1;
    for (int d = 0; d < 4; d++) exp_disp[d] = model_digit(42, d);
    for (int i = 0; i < 4 * SCAN_DIV + 2; i++) begin
      @(negedge aclk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL back_to_back idle %0d: got busy=%b done=%b, want 0 0",
                 i, bus.busy, bus.done);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge aclk);
    bus.bin_in = 14'd9876;
    bus.load   = 1'b1;
    @(negedge aclk);
    bus.load = 1'b0;
    repeat (6) @(negedge aclk);
    scan_en = 1'b0;
    aresetn = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ovf !== 1'b0 ||
        bus.digit_bcd !== 4'd0 || bus.digit_sel !== 4'b1110) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b done=%b ovf=%b bcd=%h sel=%b, want 0 0 0 0 1110",
               bus.busy, bus.done, bus.ovf, bus.digit_bcd, bus.digit_sel);
    end
    for (int d = 0; d < 4; d++) exp_disp[d] = 4'd0;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    scan_en = 1'b1;
    for (int i = 0; i < 4 * SCAN_DIV + 8; i++) begin
      @(negedge aclk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid after release %0d: got busy=%b done=%b, want 0 0",
                 i, bus.busy, bus.done);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) test_convert(int'($urandom_range(0, 16383)));
  endtask

  initial begin
    test_reset();
    test_scan();
    test_convert(1234);
    test_convert(12000);
    test_back_to_back();
    test_convert(0);
    test_convert(9999);
    test_convert(10000);
    test_convert(7);
    test_random();
    test_reset_mid();
    scan_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
